// File: rtl/softmax_norm_if.sv
// Stream bundle for softmax_norm: exponential words in, probabilities out.
// The slave modport is the normaliser's view; master is the surrounding fabric.
interface softmax_norm_if #(
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [20:0]      in_exp;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_prob;
  logic             out_last;

  modport master (
    output in_valid, in_exp, in_last, out_ready,
    input  in_ready, out_valid, out_prob, out_last
  );

  modport slave (
    input  in_valid, in_exp, in_last, out_ready,
    output in_ready, out_valid, out_prob, out_last
  );
endinterface

// File: rtl/softmax_norm.sv
// Softmax normaliser: buffers one vector of exponential words, sums them, then
// divides each word by the sum with a restoring divider. Option: SOFTMAX_NORM_ROUND_EN.
module softmax_norm #(
  parameter int N_MAX = 16,
  parameter int OUT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  softmax_norm_if.slave bus
);
  localparam int IDX_W = $clog2(N_MAX);
  localparam int ALN_W = 47;
  localparam int SUM_W = ALN_W + IDX_W;
  localparam int REM_W = SUM_W + 1;
`ifdef SOFTMAX_NORM_ROUND_EN
  localparam int Q_W = OUT_W + 1;
`else
  localparam int Q_W = OUT_W;
`endif
  localparam int ITER_W = $clog2(Q_W + 1);

  typedef enum logic [1:0] {COLLECT, DIV, OUT} state_t;

  state_t             state;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [OUT_W-1:0]   out_prob_r;
  logic               out_last_r;
  logic [SUM_W-1:0]   acc;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   last_idx;
  logic [ITER_W-1:0]  iter_cnt;
  logic               loading;

  logic [20:0]        mem [N_MAX];
  logic [SUM_W-1:0]   rem;
  logic [Q_W-1:0]     q;

  logic [REM_W-1:0]   r_sh;
  logic               take;
  logic [SUM_W-1:0]   rem_nxt;
  logic [Q_W-1:0]     q_nxt;
  logic               in_fire;

  function automatic logic [ALN_W-1:0] align_word(input logic [20:0] w);
    return ALN_W'(w[15:0]) << w[20:16];
  endfunction

  // Round half-up on the extra quotient bit; only an all-ones quotient can overflow.
  function automatic logic [OUT_W-1:0] round_sat(input logic [Q_W-1:0] qv);
`ifdef SOFTMAX_NORM_ROUND_EN
    logic [Q_W:0] s;
    s = ({1'b0, qv} + {{Q_W{1'b0}}, 1'b1}) >> 1;
    if (s[Q_W:OUT_W] != '0)
      return {OUT_W{1'b1}};
    else
      return s[OUT_W-1:0];
`else
    return qv;
`endif
  endfunction

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_prob  = out_prob_r;
  assign bus.out_last  = out_last_r;

  assign in_fire = (state == COLLECT) && in_ready_r && bus.in_valid;

  // A zero sum must never set quotient bits, so every probability reads 0.
  always_comb begin
    r_sh    = {rem, 1'b0};
    take    = (acc != '0) && (r_sh >= {1'b0, acc});
    rem_nxt = take ? SUM_W'(r_sh - {1'b0, acc}) : SUM_W'(r_sh);
    q_nxt   = q | ({{(Q_W-1){1'b0}}, take} << (ITER_W'(Q_W - 1) - iter_cnt));
  end

  always_ff @(posedge clk) begin
    if (in_fire)
      mem[wr_idx] <= bus.in_exp;
  end

  always_ff @(posedge clk) begin
    if (state == DIV) begin
      if (loading) begin
        rem <= SUM_W'(align_word(mem[rd_idx]));
        q   <= '0;
      end else begin
        rem <= rem_nxt;
        q   <= q_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_prob_r  <= '0;
      out_last_r  <= 1'b0;
      acc         <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      last_idx    <= '0;
      iter_cnt    <= '0;
      loading     <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          in_ready_r <= 1'b1;
          if (in_fire) begin
            acc    <= acc + SUM_W'(align_word(bus.in_exp));
            wr_idx <= wr_idx + IDX_W'(1);
            if (bus.in_last || wr_idx == IDX_W'(N_MAX - 1)) begin
              last_idx   <= wr_idx;
              rd_idx     <= '0;
              in_ready_r <= 1'b0;
              loading    <= 1'b1;
              state      <= DIV;
            end
          end
        end
        DIV: begin
          if (loading) begin
            loading  <= 1'b0;
            iter_cnt <= '0;
          end else begin
            iter_cnt <= iter_cnt + ITER_W'(1);
            if (iter_cnt == ITER_W'(Q_W - 1)) begin
              out_prob_r  <= round_sat(q_nxt);
              out_last_r  <= (rd_idx == last_idx);
              out_valid_r <= 1'b1;
              state       <= OUT;
            end
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (rd_idx == last_idx) begin
              acc        <= '0;
              wr_idx     <= '0;
              in_ready_r <= 1'b1;
              state      <= COLLECT;
            end else begin
              rd_idx  <= rd_idx + IDX_W'(1);
              loading <= 1'b1;
              state   <= DIV;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_norm.sv
// Scoreboard bench for softmax_norm: directed vectors push expected probabilities,
// a negedge monitor pops and compares on every output handshake.
module tb_softmax_norm;
  localparam int OUT_W = 16;
  localparam int N_MAX = 16;
`ifdef SOFTMAX_NORM_ROUND_EN
  localparam int          LAT  = 18;
  localparam logic [15:0] P2_3 = 16'hAAAB;
`else
  localparam int          LAT  = 17;
  localparam logic [15:0] P2_3 = 16'hAAAA;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  softmax_norm_if #(.OUT_W(OUT_W)) bus ();

  softmax_norm #(.N_MAX(N_MAX), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] prob;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   chk = 0;
  int   err = 0;
  int   hs  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk++;
    if (act !== req) begin
      err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [15:0] p, input logic l);
    exp_t e;
    e.prob = p;
    e.last = l;
    sb.push_back(e);
  endtask

  // Offer one word; returns at #1 after the accepting edge.
  task automatic send(input logic [20:0] w, input logic l);
    int   t;
    logic acc_now;
    t = 0;
    acc_now = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_exp   = w;
    bus.in_last  = l;
    while (!acc_now && t < 400) begin
      @(negedge clk);
      acc_now = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc_now) check("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        hs++;
        if (sb.size() == 0) begin
          chk++;
          err++;
          $display("FAIL unexpected_output actual=%h required=none", bus.out_prob);
        end else begin
          e = sb.pop_front();
          check("prob", bus.out_prob, e.prob);
          check("last", bus.out_last, e.last);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int hs0;
    bus.in_valid  = 1'b0;
    bus.in_exp    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_prob", bus.out_prob, 0);
    check("rst_out_last", bus.out_last, 0);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1;
    check("in_ready_after_edge", bus.in_ready, 1);

    // single element, full probability
    push(16'hFFFF, 1'b1);
    send({5'd16, 16'h8000}, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, LAT);
    wait_idle();

    // four equal words
    for (int i = 0; i < 4; i++) push(16'h4000, i == 3);
    for (int i = 0; i < 4; i++) send({5'd16, 16'h8000}, i == 3);
    wait_idle();

    // values 1 and 2 with downstream stall and a word offered while busy
    bus.out_ready = 1'b0;
    push(16'h5555, 1'b0);
    push(P2_3, 1'b1);
    send({5'd16, 16'h0001}, 1'b0);
    send({5'd17, 16'h0001}, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_exp   = {5'd16, 16'h7777};
    n = 0;
    while (!bus.out_valid && n < 100) begin
      check("in_ready_low_div", bus.in_ready, 0);
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_prob", bus.out_prob, 16'h5555);
      check("stall_last", bus.out_last, 0);
      check("in_ready_low_out", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();

    // zero sum
    push(16'h0000, 1'b0);
    push(16'h0000, 1'b1);
    send({5'd16, 16'h0000}, 1'b0);
    send({5'd3, 16'h0000}, 1'b1);
    wait_idle();

    // forced end at N_MAX words, 17th word must wait for the last handshake
    hs0 = hs;
    for (int i = 0; i < 16; i++) push(16'h1000, i == 15);
    for (int i = 0; i < 16; i++) send({5'd16, 16'h0100}, 1'b0);
    send({5'd16, 16'h8000}, 1'b1);
    check("held_17th_queue", sb.size(), 0);
    check("held_17th_hs", hs - hs0, 16);
    push(16'hFFFF, 1'b1);
    wait_idle();

    // reset in the middle of a division
    send({5'd16, 16'h0001}, 1'b0);
    send({5'd16, 16'h0001}, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(16'h4000, 1'b0);
    push(16'hC000, 1'b1);
    send({5'd16, 16'h0001}, 1'b0);
    send({5'd16, 16'h0003}, 1'b1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
